// File: rtl/wptr_level_handler.sv
// Write-domain pointer controller for the async FIFO: binary/Gray write pointers,
// synchronised read pointer, registered full/almost-full/level and sticky overflow.
module wptr_level_handler #(
  parameter int PTR_WIDTH    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic                 ovf_clr,
  input  logic [PTR_WIDTH:0]   g_rptr_async,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic                 w_ack,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH:0] AF_TH = (PTR_WIDTH+1)'(AFULL_THRESH);

  logic [SYNC_STAGES-1:0][PTR_WIDTH:0] sync_q;
  logic [PTR_WIDTH:0] g_rptr_sync, b_rptr_sync;
  logic [PTR_WIDTH:0] b_wptr_q, g_wptr_q, wlevel_q;
  logic [PTR_WIDTH:0] b_next_d, g_next_d, lvl_next_d;
  logic               full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  logic               accept;

  // Read pointer crosses into wclk as Gray so at most one bit is in flight.
  always_ff @(posedge wclk) begin
    if (wrst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], g_rptr_async};
  end

  assign g_rptr_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    b_rptr_sync            = '0;
    b_rptr_sync[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
    for (int i = PTR_WIDTH-1; i >= 0; i--)
      b_rptr_sync[i] = b_rptr_sync[i+1] ^ g_rptr_sync[i];
  end

  assign accept     = w_en & ~full_q;
  assign b_next_d   = b_wptr_q + {{PTR_WIDTH{1'b0}}, accept};
  assign g_next_d   = (b_next_d >> 1) ^ b_next_d;
  assign lvl_next_d = b_next_d - b_rptr_sync;

  // Full when write is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_d  = (g_next_d == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                  g_rptr_sync[PTR_WIDTH-2:0]});
  assign afull_d = (lvl_next_d >= AF_TH);
  assign ovf_d   = (w_en & full_q) | (ovf_q & ~ovf_clr);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_next_d;
      g_wptr_q <= g_next_d;
      wlevel_q <= lvl_next_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign b_wptr      = b_wptr_q;
  assign g_wptr      = g_wptr_q;
  assign waddr       = b_wptr_q[PTR_WIDTH-1:0];
  assign w_ack       = accept;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wlevel      = wlevel_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_level_handler.sv
// Directed plus randomized bench for wptr_level_handler against an occupancy-count model.
module tb_wptr_level_handler;

  localparam int PW = 3;
  localparam int SS = 2;
  localparam int AF = 6;
  localparam int DEPTH = 1 << PW;
  localparam int MODV  = 2 * DEPTH;

  logic          wclk = 1'b0;
  logic          wrst, w_en, ovf_clr;
  logic [PW:0]   g_rptr_async;
  logic [PW:0]   b_wptr, g_wptr, wlevel;
  logic [PW-1:0] waddr;
  logic          w_ack, full, almost_full, overflow;

  wptr_level_handler #(.PTR_WIDTH(PW), .SYNC_STAGES(SS), .AFULL_THRESH(AF)) dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .ovf_clr(ovf_clr),
    .g_rptr_async(g_rptr_async), .b_wptr(b_wptr), .g_wptr(g_wptr),
    .waddr(waddr), .w_ack(w_ack), .full(full), .almost_full(almost_full),
    .wlevel(wlevel), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: write count and read count as plain integers mod 2*DEPTH.
  int m_wp, m_lvl, rp;
  bit m_full, m_af, m_ovf;
  int m_hist[SS];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW:0] to_gray(input int b);
    logic [PW:0] v;
    v = PW'(b) | ((PW+1)'(b) & (PW+1)'(1 << PW));
    v = (PW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, ".b_wptr"}, int'(b_wptr), m_wp);
    chk({ph, ".g_wptr"}, int'(g_wptr), int'(to_gray(m_wp)));
    chk({ph, ".waddr"},  int'(waddr),  m_wp % DEPTH);
    chk({ph, ".full"},   int'(full),   int'(m_full));
    chk({ph, ".afull"},  int'(almost_full), int'(m_af));
    chk({ph, ".wlevel"}, int'(wlevel), m_lvl);
    chk({ph, ".ovf"},    int'(overflow), int'(m_ovf));
  endtask

  // One wclk cycle: drive, check the combinational ack, clock, update model, check state.
  task automatic step(input string ph, input bit rst, input bit we, input bit clr);
    int acc, rsync;
    wrst = rst; w_en = we; ovf_clr = clr;
    g_rptr_async = to_gray(rp);
    #1;
    chk({ph, ".w_ack"}, int'(w_ack), int'(we && !m_full));
    @(posedge wclk);
    if (rst) begin
      m_wp = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
      for (int i = 0; i < SS; i++) m_hist[i] = 0;
    end else begin
      acc   = (we && !m_full) ? 1 : 0;
      rsync = m_hist[SS-1];
      m_ovf = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_wp  = (m_wp + acc) % MODV;
      m_lvl = (m_wp - rsync + MODV) % MODV;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= AF);
      for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = rp;
    end
    #1;
    check_outputs(ph);
  endtask

  function automatic int occ();
    return (m_wp - rp + MODV) % MODV;
  endfunction

  initial begin
    bit we, clr, rs;
    m_wp = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    for (int i = 0; i < SS; i++) m_hist[i] = 0;
    wrst = 1; w_en = 0; ovf_clr = 0; rp = 0; g_rptr_async = '0;
    @(negedge wclk);

    // Reset with activity on the inputs (Gray 0110 = binary 4).
    rp = 4;
    step("rst", 1, 1, 0);
    step("rst", 1, 1, 0);
    chk("rst.g_wptr_zero", int'(g_wptr), 0);
    rp = 0;
    step("rst_rel", 0, 1, 0);
    chk("rst_rel.b_wptr_one", int'(b_wptr), 1);

    // Fill: seven more writes reach DEPTH.
    for (int k = 2; k <= DEPTH; k++) begin
      step("fill", 0, 1, 0);
      if (k == AF) chk("fill.afull_at_6", int'(almost_full), 1);
      if (k == AF - 1) chk("fill.afull_before_6", int'(almost_full), 0);
    end
    chk("fill.full", int'(full), 1);
    chk("fill.b_wptr_8", int'(b_wptr), 8);
    chk("fill.g_wptr_1100", int'(g_wptr), 12);
    chk("fill.wlevel_8", int'(wlevel), 8);

    // Overflow set, clear, and set-beats-clear.
    step("ovf", 0, 1, 0);
    chk("ovf.set", int'(overflow), 1);
    chk("ovf.hold_ptr", int'(b_wptr), 8);
    step("ovf", 0, 0, 1);
    chk("ovf.clr", int'(overflow), 0);
    step("ovf", 0, 1, 1);
    chk("ovf.set_wins", int'(overflow), 1);

    // Release: read pointer to 3, visible after SYNC_STAGES+1 edges.
    rp = 3;
    step("rel", 0, 0, 0);
    step("rel", 0, 0, 0);
    chk("rel.still_full", int'(full), 1);
    step("rel", 0, 0, 0);
    chk("rel.full_low", int'(full), 0);
    chk("rel.wlevel_5", int'(wlevel), 5);
    chk("rel.afull_low", int'(almost_full), 0);

    // Wrap: continuous writes, reader trails the writer by two.
    for (int k = 0; k < 40; k++) begin
      if (occ() > 2 && rp != m_wp) rp = (rp + 1) % MODV;
      step("wrap", 0, 1, 0);
      chk("wrap.no_full", int'(full), 0);
    end

    // Mid-operation reset from a non-trivial state.
    step("mid", 0, 1, 0);
    rp = 0;
    step("mid_rst", 1, 1, 0);
    chk("mid_rst.level_zero", int'(wlevel), 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rs  = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 10);
      if (rs) rp = 0;
      else if (occ() > 0 && $urandom_range(0, 99) < 45) rp = (rp + 1) % MODV;
      step("rand", rs, we, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
